// File: rtl/connect4_turn_controller.sv
// rtl/connect4_turn_controller.sv - Connect4 move sequencer: legality check, landing cell, drop handshake, turn and fill tracking
// Optional feature macro: TURN_TIMEOUT_EN (forced turn pass after TIMEOUT_CYCLES idle cycles in WAIT)
module connect4_turn_controller #(
  parameter int NUM_ROWS       = 4,
  parameter bit FIRST_PLAYER   = 1'b0,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       new_game,
  input  logic       sel_valid,
  input  logic [3:0] sel_column,
  output logic       drop_valid,
  input  logic       drop_ready,
  output logic [3:0] drop_position,
  output logic       drop_player,
  output logic       current_player,
  output logic [3:0] column_full,
  output logic       board_full,
  output logic       illegal_move,
  output logic       turn_timeout
);

  typedef enum logic [1:0] {
    S_WAIT    = 2'd0,
    S_ISSUE   = 2'd1,
    S_ADVANCE = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  localparam logic [2:0] FULL_COUNT = 3'(NUM_ROWS);

  state_t     state;
  logic [2:0] fill [4];
  logic [1:0] col_q;

  logic       sel_legal;
  logic [1:0] sel_col;
  logic [3:0] fill_full;

`ifdef TURN_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] IDLE_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] idle_cnt;
  logic          timeout_q;

  assign turn_timeout = timeout_q;
`else
  assign turn_timeout = 1'b0;
`endif

  // Decode the active-low one-hot column code; any other pattern is illegal
  always_comb begin
    sel_legal = 1'b1;
    sel_col   = 2'd0;
    case (sel_column)
      4'b1110: sel_col = 2'd0;
      4'b1101: sel_col = 2'd1;
      4'b1011: sel_col = 2'd2;
      4'b0111: sel_col = 2'd3;
      default: sel_legal = 1'b0;
    endcase
  end

  // Live per-column full flags straight from the fill counters
  always_comb begin
    for (int c = 0; c < 4; c++) begin
      fill_full[c] = (fill[c] == FULL_COUNT);
    end
  end

  // Move sequencer: all state, counters and outputs registered here
  always_ff @(posedge clk) begin
    if (!rst_n || new_game) begin
      state          <= S_WAIT;
      for (int c = 0; c < 4; c++) begin
        fill[c] <= 3'd0;
      end
      col_q          <= 2'd0;
      current_player <= FIRST_PLAYER;
      drop_valid     <= 1'b0;
      drop_position  <= 4'd0;
      drop_player    <= 1'b0;
      illegal_move   <= 1'b0;
      column_full    <= 4'd0;
      board_full     <= 1'b0;
`ifdef TURN_TIMEOUT_EN
      idle_cnt       <= '0;
      timeout_q      <= 1'b0;
`endif
    end else begin
      illegal_move <= 1'b0;
`ifdef TURN_TIMEOUT_EN
      timeout_q    <= 1'b0;
`endif
      case (state)
        S_WAIT: begin
          if (sel_valid && sel_legal && !fill_full[sel_col]) begin
            // A legal press always beats a timeout landing in the same cycle
            col_q         <= sel_col;
            drop_position <= {fill[sel_col][1:0], sel_col};
            drop_player   <= current_player;
            drop_valid    <= 1'b1;
            state         <= S_ISSUE;
`ifdef TURN_TIMEOUT_EN
            idle_cnt      <= '0;
`endif
          end else begin
            if (sel_valid) begin
              illegal_move <= 1'b1;
            end
`ifdef TURN_TIMEOUT_EN
            // Illegal presses do not restart the idle count
            if (idle_cnt == IDLE_LAST) begin
              timeout_q      <= 1'b1;
              current_player <= ~current_player;
              idle_cnt       <= '0;
            end else begin
              idle_cnt <= idle_cnt + 1'b1;
            end
`endif
          end
        end

        S_ISSUE: begin
          // Presses here are dropped silently; position and player stay frozen
          if (drop_ready) begin
            if (fill[col_q] != FULL_COUNT) begin
              fill[col_q] <= fill[col_q] + 3'd1;
            end
            drop_valid <= 1'b0;
            state      <= S_ADVANCE;
          end
        end

        S_ADVANCE: begin
          // Counters already hold the completed drop, so full flags are current
          current_player <= ~current_player;
          column_full    <= fill_full;
          board_full     <= &fill_full;
`ifdef TURN_TIMEOUT_EN
          idle_cnt       <= '0;
`endif
          state          <= (&fill_full) ? S_DONE : S_WAIT;
        end

        S_DONE: begin
          state <= S_DONE;
        end

        default: begin
          state <= S_WAIT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_connect4_turn_controller.sv
// tb/tb_connect4_turn_controller.sv - directed scoreboard bench for connect4_turn_controller
module tb_connect4_turn_controller;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       new_game;
  logic       sel_valid;
  logic [3:0] sel_column;
  logic       drop_valid;
  logic       drop_ready;
  logic [3:0] drop_position;
  logic       drop_player;
  logic       current_player;
  logic [3:0] column_full;
  logic       board_full;
  logic       illegal_move;
  logic       turn_timeout;

  always #5 clk = ~clk;

  connect4_turn_controller #(
    .NUM_ROWS      (4),
    .FIRST_PLAYER  (1'b0),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .new_game      (new_game),
    .sel_valid     (sel_valid),
    .sel_column    (sel_column),
    .drop_valid    (drop_valid),
    .drop_ready    (drop_ready),
    .drop_position (drop_position),
    .drop_player   (drop_player),
    .current_player(current_player),
    .column_full   (column_full),
    .board_full    (board_full),
    .illegal_move  (illegal_move),
    .turn_timeout  (turn_timeout)
  );

  typedef struct packed {
    logic [3:0] pos;
    logic       player;
  } drop_t;

  int    checks = 0;
  int    errors = 0;
  drop_t exp_q[$];
  int    mfill[4];
  logic  mplayer;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int col_of(input logic [3:0] code);
    case (code)
      4'b1110: return 0;
      4'b1101: return 1;
      4'b1011: return 2;
      4'b0111: return 3;
      default: return -1;
    endcase
  endfunction

  function automatic logic [3:0] code_of(input int c);
    logic [3:0] one;
    one = 4'b0001 << c;
    return ~one;
  endfunction

  function automatic logic [3:0] model_full();
    logic [3:0] v;
    for (int c = 0; c < 4; c++) v[c] = (mfill[c] == 4);
    return v;
  endfunction

  // Compare the head of the scoreboard against what the DUT is presenting
  task automatic pop_and_check(input string tag);
    drop_t e;
    if (exp_q.size() == 0) begin
      chk({tag, " scoreboard empty"}, 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      chk({tag, " drop_position"}, 32'(drop_position), 32'(e.pos));
      chk({tag, " drop_player"}, 32'(drop_player), 32'(e.player));
    end
  endtask

  // One press in WAIT with drop_ready already high; the model decides legality
  task automatic move(input logic [3:0] code, input string tag);
    int   c;
    int   n;
    logic legal;
    c     = col_of(code);
    legal = (c >= 0) && (mfill[(c >= 0) ? c : 0] < 4);
    if (legal) exp_q.push_back({4'(mfill[c] * 4 + c), mplayer});
    sel_valid  = 1'b1;
    sel_column = code;
    tick();
    sel_valid  = 1'b0;
    sel_column = 4'hF;
    if (legal) begin
      chk({tag, " drop_valid"}, 32'(drop_valid), 32'd1);
      chk({tag, " no illegal"}, 32'(illegal_move), 32'd0);
      chk({tag, " no timeout"}, 32'(turn_timeout), 32'd0);
      pop_and_check(tag);
      n = 0;
      while (!(drop_valid && drop_ready) && n < 50) begin
        tick();
        n++;
      end
      if (n == 50) chk({tag, " handshake wait"}, 32'd0, 32'd1);
      tick();
      chk({tag, " drop_valid low"}, 32'(drop_valid), 32'd0);
      mfill[c]++;
      tick();
      mplayer = ~mplayer;
      chk({tag, " current_player"}, 32'(current_player), 32'(mplayer));
      chk({tag, " column_full"}, 32'(column_full), 32'(model_full()));
    end else begin
      chk({tag, " illegal pulse"}, 32'(illegal_move), 32'd1);
      chk({tag, " no drop"}, 32'(drop_valid), 32'd0);
      tick();
      chk({tag, " illegal end"}, 32'(illegal_move), 32'd0);
      chk({tag, " player kept"}, 32'(current_player), 32'(mplayer));
    end
  endtask

  task automatic model_clear();
    for (int c = 0; c < 4; c++) mfill[c] = 0;
    mplayer = 1'b0;
  endtask

  initial begin
    drop_t hold;
    rst_n      = 1'b0;
    new_game   = 1'b0;
    sel_valid  = 1'b0;
    sel_column = 4'hF;
    drop_ready = 1'b1;
    model_clear();
    tick();
    tick();
    chk("reset drop_valid", 32'(drop_valid), 32'd0);
    chk("reset drop_position", 32'(drop_position), 32'd0);
    chk("reset drop_player", 32'(drop_player), 32'd0);
    chk("reset current_player", 32'(current_player), 32'd0);
    chk("reset column_full", 32'(column_full), 32'd0);
    chk("reset board_full", 32'(board_full), 32'd0);
    chk("reset illegal_move", 32'(illegal_move), 32'd0);
    chk("reset turn_timeout", 32'(turn_timeout), 32'd0);
    rst_n = 1'b1;

    // First move into column 0
    move(4'b1110, "t1");

    // Fill column 2, then one press too many
    for (int i = 0; i < 4; i++) move(4'b1011, "t2");
    chk("t2 column_full", 32'(column_full), 32'h4);
    move(4'b1011, "t2 overfill");

    // Malformed codes
    move(4'b1100, "t3 two-zero");
    move(4'b1111, "t3 no-zero");

    // Stalled writer: extra press during ISSUE must vanish
    drop_ready = 1'b0;
    exp_q.push_back({4'(mfill[0] * 4), mplayer});
    sel_valid  = 1'b1;
    sel_column = 4'b1110;
    tick();
    sel_valid  = 1'b0;
    sel_column = 4'hF;
    chk("t4 drop_valid", 32'(drop_valid), 32'd1);
    hold = {drop_position, drop_player};
    pop_and_check("t4");
    for (int i = 0; i < 5; i++) begin
      if (i == 1) begin
        sel_valid  = 1'b1;
        sel_column = 4'b0111;
      end
      tick();
      sel_valid  = 1'b0;
      sel_column = 4'hF;
      chk("t4 hold valid", 32'(drop_valid), 32'd1);
      chk("t4 hold position", 32'(drop_position), 32'(hold.pos));
      chk("t4 stall illegal", 32'(illegal_move), 32'd0);
    end
    drop_ready = 1'b1;
    tick();
    chk("t4 drop_valid low", 32'(drop_valid), 32'd0);
    mfill[0]++;
    tick();
    mplayer = ~mplayer;
    chk("t4 current_player", 32'(current_player), 32'(mplayer));

    // Fill every remaining cell
    for (int c = 0; c < 4; c++) begin
      while (mfill[c] < 4) move(code_of(c), "t5");
    end
    chk("t5 board_full", 32'(board_full), 32'd1);
    chk("t5 column_full", 32'(column_full), 32'hF);
    sel_valid  = 1'b1;
    sel_column = 4'b1101;
    tick();
    sel_valid  = 1'b0;
    sel_column = 4'b1100;
    sel_valid  = 1'b1;
    tick();
    sel_valid  = 1'b0;
    sel_column = 4'hF;
    chk("t5 done no illegal", 32'(illegal_move), 32'd0);
    chk("t5 done no drop", 32'(drop_valid), 32'd0);
    tick();
    chk("t5 done still no illegal", 32'(illegal_move), 32'd0);
    new_game = 1'b1;
    tick();
    new_game = 1'b0;
    model_clear();
    chk("t5 new_game board_full", 32'(board_full), 32'd0);
    chk("t5 new_game column_full", 32'(column_full), 32'd0);
    chk("t5 new_game player", 32'(current_player), 32'd0);

    // new_game during a pending drop abandons it
    drop_ready = 1'b0;
    sel_valid  = 1'b1;
    sel_column = 4'b1101;
    tick();
    sel_valid  = 1'b0;
    sel_column = 4'hF;
    chk("ng drop pending", 32'(drop_valid), 32'd1);
    chk("ng pending position", 32'(drop_position), 32'd1);
    new_game = 1'b1;
    tick();
    new_game = 1'b0;
    chk("ng drop cancelled", 32'(drop_valid), 32'd0);
    chk("ng player", 32'(current_player), 32'd0);
    drop_ready = 1'b1;
    move(4'b1101, "ng replay");

`ifdef TURN_TIMEOUT_EN
    new_game = 1'b1;
    tick();
    new_game = 1'b0;
    model_clear();
    for (int i = 0; i < 7; i++) begin
      tick();
      chk("t6 early timeout", 32'(turn_timeout), 32'd0);
    end
    tick();
    chk("t6 timeout pulse", 32'(turn_timeout), 32'd1);
    chk("t6 timeout player", 32'(current_player), 32'd1);
    mplayer = 1'b1;
    tick();
    chk("t6 pulse end", 32'(turn_timeout), 32'd0);
    for (int i = 0; i < 6; i++) tick();
    move(4'b1110, "t6 terminal press");
`else
    for (int i = 0; i < 12; i++) begin
      tick();
      chk("no timeout idle", 32'(turn_timeout), 32'd0);
    end
`endif

    chk("scoreboard drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/connect4_turn_controller.md
Name: connect4_turn_controller

Overview:
Sequences moves for the 4-column Connect4 board. Accepts column selections from the active player, rejects illegal moves, computes the landing cell, and issues one drop per move to the board writer through a valid/ready handshake. Owns per-column fill counters, whose-turn state and board-full detection. Sits between the debounced column buttons and the board memory/display logic.

Parameters:
NUM_ROWS, 4, rows per column; legal range 1..4. Position encoding row*4+col always fits 4 bits.
FIRST_PLAYER, 0, player who moves first after reset or new_game.
TIMEOUT_CYCLES, 1000, idle cycles before a forced turn pass. Used only with TURN_TIMEOUT_EN.

Ports:
clk  in  1  system clock; all logic on posedge.
rst_n  in  1  synchronous active-low reset.
new_game  in  1  one-cycle pulse: clear board state and restart from FIRST_PLAYER.
sel_valid  in  1  one-cycle pulse: a column button was pressed.
sel_column  in  4  active-low one-hot column select (4'b1110 = col 0 ... 4'b0111 = col 3).
drop_valid  out  1  drop request to the board writer.
drop_ready  in  1  board writer accepts the drop.
drop_position  out  4  landing cell, row*4+col.
drop_player  out  1  owner of the dropped piece.
current_player  out  1  player whose turn it is.
column_full  out  4  bit c = column c holds NUM_ROWS pieces.
board_full  out  1  all columns full.
illegal_move  out  1  one-cycle pulse on a rejected selection.
turn_timeout  out  1  one-cycle pulse on a forced pass. Tied 0 without TURN_TIMEOUT_EN.

Behaviour:
- Reset (rst_n=0 at posedge): state=WAIT, fill counters=0, current_player=FIRST_PLAYER, drop_valid=0, drop_position=0, drop_player=0, illegal_move=0, turn_timeout=0, column_full=0, board_full=0.
- FSM states: WAIT, ISSUE, ADVANCE, DONE.
- WAIT
  - sel_valid=1 with a legal code (exactly one 0 bit) on a non-full column:
    - latch col and row=fill[col];
    - drop_position=row*4+col, drop_player=current_player;
    - go to ISSUE. drop_valid is high in the cycle after sel_valid.
  - sel_valid=1 with a non-one-hot code (e.g. 4'b1100, 4'b1111) or a full column:
    - illegal_move pulses for 1 cycle, in the cycle after sel_valid;
    - no state change; turn does not pass.
- ISSUE
  - drop_valid held high; drop_position and drop_player held stable until drop_valid && drop_ready.
  - sel_valid is ignored: no illegal_move pulse and no queuing.
  - On handshake: fill[col] increments, drop_valid drops next cycle, go to ADVANCE.
- ADVANCE (1 cycle)
  - Toggle current_player.
  - Recompute column_full and board_full from the updated counters.
  - Go to DONE if board_full, else WAIT.
- DONE
  - All sel_valid are ignored, with no illegal_move pulse.
  - Only new_game or reset leaves this state.
- Timing: drop_valid high in cycle N+1 after accept in cycle N. Minimum move-to-move spacing is 3 cycles with drop_ready tied high.
- Counters: width 3 bits, saturating at NUM_ROWS. They never wrap. The full check uses fill[col]==NUM_ROWS.
- new_game (any state)
  - Same effect as reset, except it is a synchronous pulse.
  - It drops any pending drop_valid without a handshake; the board writer is cleared separately.
  - Takes priority over sel_valid and drop_ready in the same cycle.
- rst_n low mid-ISSUE: drop_valid=0 next cycle; that move is lost.
- column_full and board_full are registered and reflect only completed drops.

Optional Feature:
TURN_TIMEOUT_EN
- Defined:
  - A counter runs while in WAIT and resets on every accepted move, on entry to WAIT, and on new_game.
  - On reaching TIMEOUT_CYCLES-1: turn_timeout pulses 1 cycle, current_player toggles, the counter clears. No drop occurs.
  - An illegal selection does not reset the counter.
  - If a legal sel_valid arrives in the terminal cycle, the move wins and no timeout fires.
- Undefined: no counter logic; turn_timeout is tied 0; a player may wait indefinitely.

Test Plan:
1. Reset, then sel_column=4'b1110 pulse with drop_ready=1 -> next cycle drop_valid=1, drop_position=0, drop_player=0; after ADVANCE current_player=1.
2. Four legal drops into col 2 (4'b1011), drop_ready=1 -> positions 2, 6, 10, 14 with alternating drop_player; then column_full=4'b0100. A fifth press of 4'b1011 -> illegal_move pulse, no drop_valid, current_player unchanged.
3. sel_column=4'b1100, then 4'b1111 in WAIT -> two illegal_move pulses; no state change.
4. Hold drop_ready=0 for 5 cycles after a legal select, pressing 4'b0111 meanwhile -> drop_valid stays high, drop_position constant, no illegal_move, the extra press ignored; drop_ready=1 -> exactly one fill increment.
5. Fill all 16 cells -> board_full=1, FSM in DONE; further presses produce nothing. new_game -> board_full=0, column_full=0, current_player=FIRST_PLAYER.
6. With TURN_TIMEOUT_EN and TIMEOUT_CYCLES=8: idle in WAIT for 8 cycles -> turn_timeout pulses, current_player toggles. A legal press in cycle 8 -> drop issued, no turn_timeout.
